// File: rtl/elevator_call_scheduler_pkg.sv
// Shared types and defaults for the elevator call scheduler: FSM state encoding,
// default timing constants and the floor-index to display-code mapping.
package elevator_call_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    MOVE_UP   = 2'b01,
    MOVE_DOWN = 2'b10,
    DOOR      = 2'b11
  } state_e;

  localparam int DEF_NUM_FLOORS    = 3;
  localparam int DEF_TRAVEL_CYCLES = 8;
  localparam int DEF_DOOR_CYCLES   = 4;

  // The 7-segment decoder expects 1-based floor numbers.
  function automatic logic [3:0] floor_to_code(input logic [3:0] floor_idx);
    return floor_idx + 4'd1;
  endfunction

endpackage

// File: rtl/elevator_timer.sv
// Clearable up-counter with a programmable terminal count, shared by the
// travel and door-dwell phases of the scheduler.
module elevator_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] last_i,
  output logic         tc_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i)
      count_d = '0;
    else if (en_i)
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign tc_o = (count_q == last_i);

endmodule

// File: rtl/elevator_call_scheduler.sv
// SCAN elevator controller: latches floor calls, moves the car one floor per
// travel period, and holds the door open for a restartable dwell period.
module elevator_call_scheduler
  import elevator_call_scheduler_pkg::*;
#(
  parameter int NUM_FLOORS    = DEF_NUM_FLOORS,
  parameter int TRAVEL_CYCLES = DEF_TRAVEL_CYCLES,
  parameter int DOOR_CYCLES   = DEF_DOOR_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] call_req,
  output logic                  motor_up,
  output logic                  motor_down,
  output logic                  door_open,
  output logic [3:0]            floor_code,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  dir_up
);

  localparam int FW   = $clog2(NUM_FLOORS);
  localparam int MAXC = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TW   = $clog2(MAXC);
  localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LAST   = TW'(DOOR_CYCLES - 1);
  localparam logic [FW-1:0] TOP_FLOOR   = FW'(NUM_FLOORS - 1);

  state_e                state_q, state_d;
  logic [FW-1:0]         floor_q, floor_d;
  logic [3:0]            code_q;
  logic [NUM_FLOORS-1:0] pending_q, pending_d, set_mask, clr_mask;
  logic                  dir_up_q, dir_up_d;
  logic                  tmr_clr, tmr_en, tmr_tc;
  logic [TW-1:0]         tmr_last;

  function automatic logic calls_above(input logic [NUM_FLOORS-1:0] p, input logic [FW-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++)
      if (i > int'(f) && p[i]) r = 1'b1;
    return r;
  endfunction

  function automatic logic calls_below(input logic [NUM_FLOORS-1:0] p, input logic [FW-1:0] f);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_FLOORS; i++)
      if (i < int'(f) && p[i]) r = 1'b1;
    return r;
  endfunction

  elevator_timer #(.W(TW)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (tmr_clr),
    .en_i   (tmr_en),
    .last_i (tmr_last),
    .tc_o   (tmr_tc)
  );

  always_comb begin
    state_d  = state_q;
    floor_d  = floor_q;
    dir_up_d = dir_up_q;
    tmr_clr  = 1'b0;
    tmr_en   = 1'b0;
    tmr_last = TRAVEL_LAST;
    unique case (state_q)
      IDLE: begin
        if (pending_q[floor_q])
          state_d = DOOR;
        else if (dir_up_q && calls_above(pending_q, floor_q))
          state_d = MOVE_UP;
        else if (calls_below(pending_q, floor_q)) begin
          state_d  = MOVE_DOWN;
          dir_up_d = 1'b0;
        end else if (calls_above(pending_q, floor_q)) begin
          state_d  = MOVE_UP;
          dir_up_d = 1'b1;
        end
      end
      MOVE_UP: begin
        tmr_en = 1'b1;
        if (tmr_tc) begin
          tmr_clr = 1'b1;
          floor_d = floor_q + 1'b1;
          if (pending_q[floor_d])
            state_d = DOOR;
          else if (!calls_above(pending_q, floor_d))
            state_d = IDLE;
        end
      end
      MOVE_DOWN: begin
        tmr_en = 1'b1;
        if (tmr_tc) begin
          tmr_clr = 1'b1;
          floor_d = floor_q - 1'b1;
          if (pending_q[floor_d])
            state_d = DOOR;
          else if (!calls_below(pending_q, floor_d))
            state_d = IDLE;
        end
      end
      DOOR: begin
        tmr_last = DOOR_LAST;
        if (call_req[floor_q])
          tmr_clr = 1'b1;
        else if (tmr_tc) begin
          tmr_clr = 1'b1;
          state_d = IDLE;
        end else
          tmr_en = 1'b1;
      end
    endcase
  end

  // A call for the floor being served extends dwell instead of latching; arrival clears it.
  always_comb begin
    set_mask = call_req;
    if (state_q == DOOR)
      set_mask[floor_q] = 1'b0;
    clr_mask = '0;
    if (state_d == DOOR)
      clr_mask[floor_d] = 1'b1;
    pending_d = (pending_q | set_mask) & ~clr_mask;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      floor_q   <= '0;
      code_q    <= 4'd1;
      pending_q <= '0;
      dir_up_q  <= 1'b1;
    end else begin
      assert (!(state_q == MOVE_UP && tmr_tc && floor_q == TOP_FLOOR));
      assert (!(state_q == MOVE_DOWN && tmr_tc && floor_q == '0));
      state_q   <= state_d;
      floor_q   <= floor_d;
      code_q    <= floor_to_code(4'(floor_d));
      pending_q <= pending_d;
      dir_up_q  <= dir_up_d;
    end
  end

  assign motor_up   = (state_q == MOVE_UP);
  assign motor_down = (state_q == MOVE_DOWN);
  assign door_open  = (state_q == DOOR);
  assign floor_code = code_q;
  assign pending    = pending_q;
  assign dir_up     = dir_up_q;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed bench for the elevator scheduler with short timing (travel 4, dwell 3).
module tb_elevator_call_scheduler;

  logic       clk;
  logic       rst_n;
  logic [2:0] call_req;
  logic       motor_up, motor_down, door_open, dir_up;
  logic [3:0] floor_code;
  logic [2:0] pending;

  int pass_cnt  = 0;
  int total_cnt = 0;

  elevator_call_scheduler #(
    .NUM_FLOORS    (3),
    .TRAVEL_CYCLES (4),
    .DOOR_CYCLES   (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .call_req   (call_req),
    .motor_up   (motor_up),
    .motor_down (motor_down),
    .door_open  (door_open),
    .floor_code (floor_code),
    .pending    (pending),
    .dir_up     (dir_up)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  always @(negedge clk)
    if (rst_n === 1'b1)
      check("motor_exclusive", {3'b0, motor_up & motor_down}, 4'd0);

  initial begin
    rst_n    = 1'b0;
    call_req = 3'b000;
    ticks(2);
    check("rst_code", floor_code, 4'd1);
    check("rst_pending", {1'b0, pending}, 4'd0);
    check("rst_outs", {1'b0, motor_up, motor_down, door_open}, 4'd0);
    check("rst_dir", {3'b0, dir_up}, 4'd1);
    rst_n = 1'b1;
    ticks(10);
    check("idle_code", floor_code, 4'd1);
    check("idle_outs", {1'b0, motor_up, motor_down, door_open}, 4'd0);

    // Single call up from floor 0 to floor index 2
    call_req = 3'b100;
    tick();                        // E1
    call_req = 3'b000;
    check("up_pend_e1", {1'b0, pending}, 4'b0100);
    check("up_motor_e1", {3'b0, motor_up}, 4'd0);
    tick();                        // E2
    check("up_motor_e2", {3'b0, motor_up}, 4'd1);
    ticks(3);                      // E5
    check("up_code_e5", floor_code, 4'd1);
    tick();                        // E6
    check("up_code_e6", floor_code, 4'd2);
    check("up_motor_e6", {3'b0, motor_up}, 4'd1);
    ticks(3);                      // E9
    check("up_code_e9", floor_code, 4'd2);
    tick();                        // E10
    check("up_code_e10", floor_code, 4'd3);
    check("up_door_e10", {1'b0, motor_up, motor_down, door_open}, 4'b0001);
    check("up_pend_e10", {1'b0, pending}, 4'd0);
    ticks(2);                      // E12
    check("up_door_e12", {3'b0, door_open}, 4'd1);
    tick();                        // E13
    check("up_idle_e13", {1'b0, motor_up, motor_down, door_open}, 4'd0);

    // Return to floor 0: downward travel sets dir_up low
    call_req = 3'b001;
    tick();
    call_req = 3'b000;
    tick();                        // E2
    check("dn_motor_e2", {1'b0, motor_up, motor_down, door_open}, 4'b0010);
    check("dn_dir_e2", {3'b0, dir_up}, 4'd0);
    ticks(8);                      // E10
    check("dn_code_e10", floor_code, 4'd1);
    check("dn_door_e10", {3'b0, door_open}, 4'd1);
    ticks(3);                      // E13

    // Call at current floor, then dwell restart
    call_req = 3'b001;
    tick();                        // E1
    call_req = 3'b000;
    check("cur_pend_e1", {1'b0, pending}, 4'b0001);
    tick();                        // E2
    check("cur_door_e2", {1'b0, motor_up, motor_down, door_open}, 4'b0001);
    check("cur_pend_e2", {1'b0, pending}, 4'd0);
    tick();                        // E3
    call_req = 3'b001;
    tick();                        // E4: timer restarted
    call_req = 3'b000;
    check("cur_pend_e4", {1'b0, pending}, 4'd0);
    tick();                        // E5
    check("cur_door_e5", {3'b0, door_open}, 4'd1);
    tick();                        // E6
    check("cur_door_e6", {3'b0, door_open}, 4'd1);
    tick();                        // E7
    check("cur_door_e7", {1'b0, motor_up, motor_down, door_open}, 4'd0);

    // SCAN ordering: calls for floor indices 1 and 2
    call_req = 3'b110;
    tick();                        // E1
    call_req = 3'b000;
    check("scan_pend_e1", {1'b0, pending}, 4'b0110);
    tick();                        // E2
    check("scan_motor_e2", {3'b0, motor_up}, 4'd1);
    check("scan_dir_e2", {3'b0, dir_up}, 4'd1);
    ticks(4);                      // E6
    check("scan_code_e6", floor_code, 4'd2);
    check("scan_door_e6", {3'b0, door_open}, 4'd1);
    check("scan_pend_e6", {1'b0, pending}, 4'b0100);
    ticks(3);                      // E9
    check("scan_idle_e9", {1'b0, motor_up, motor_down, door_open}, 4'd0);
    tick();                        // E10
    check("scan_motor_e10", {3'b0, motor_up}, 4'd1);
    ticks(4);                      // E14
    check("scan_code_e14", floor_code, 4'd3);
    check("scan_door_e14", {3'b0, door_open}, 4'd1);
    check("scan_dir_e14", {3'b0, dir_up}, 4'd1);
    ticks(3);                      // E17

    // Reset with the car parked at the top: position is not recovered
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst2_code", floor_code, 4'd1);
    check("rst2_dir", {3'b0, dir_up}, 4'd1);

    // Reversal: call behind the car while moving up is served after the top stop
    call_req = 3'b100;
    tick();                        // E1
    call_req = 3'b000;
    tick();                        // E2
    tick();                        // E3
    call_req = 3'b001;
    tick();                        // E4
    call_req = 3'b000;
    check("rev_pend_e4", {1'b0, pending}, 4'b0101);
    ticks(2);                      // E6
    check("rev_code_e6", floor_code, 4'd2);
    check("rev_motor_e6", {1'b0, motor_up, motor_down, door_open}, 4'b0100);
    ticks(4);                      // E10
    check("rev_code_e10", floor_code, 4'd3);
    check("rev_door_e10", {3'b0, door_open}, 4'd1);
    check("rev_pend_e10", {1'b0, pending}, 4'b0001);
    ticks(4);                      // E14
    check("rev_motor_e14", {1'b0, motor_up, motor_down, door_open}, 4'b0010);
    check("rev_dir_e14", {3'b0, dir_up}, 4'd0);
    ticks(7);                      // E21
    check("rev_motor_e21", {3'b0, motor_down}, 4'd1);
    check("rev_code_e21", floor_code, 4'd2);
    tick();                        // E22
    check("rev_code_e22", floor_code, 4'd1);
    check("rev_door_e22", {1'b0, motor_up, motor_down, door_open}, 4'b0001);
    check("rev_pend_e22", {1'b0, pending}, 4'd0);
    ticks(3);

    // Reset mid-move after the car has passed floor index 1
    call_req = 3'b100;
    tick();
    call_req = 3'b000;
    ticks(5);                      // E6
    check("mrst_code_e6", floor_code, 4'd2);
    check("mrst_motor_e6", {3'b0, motor_up}, 4'd1);
    rst_n    = 1'b0;
    call_req = 3'b010;
    tick();
    check("mrst_motor", {1'b0, motor_up, motor_down, door_open}, 4'd0);
    check("mrst_code", floor_code, 4'd1);
    check("mrst_pend", {1'b0, pending}, 4'd0);
    rst_n    = 1'b1;
    call_req = 3'b000;
    ticks(4);
    check("mrst_idle", {1'b0, motor_up, motor_down, door_open}, 4'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
